borrow_lookahead_subtractor: RTL and testbench
==============================================

BORROW_LOOKAHEAD_SUBTRACTOR -- requirements
Module: borrow_lookahead_subtractor

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH SHALL default to 12; it is the operand width and SHALL be a multiple of 3 and at least 3.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: an operand set is presented.
REQ-006 Port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-007 Port a, input, WIDTH bits: minuend, unsigned or two's complement.
REQ-008 Port b, input, WIDTH bits: subtrahend.
REQ-009 Port bin, input, 1 bit: borrow-in.
REQ-010 Port out_valid, output, 1 bit: a result is presented.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 Port diff, output, WIDTH bits: the result a - b - bin mod 2^WIDTH.
REQ-013 Port bout, output, 1 bit: borrow-out; bout = 1 iff a < b + bin (unsigned).
REQ-014 Port ovf, output, 1 bit: signed overflow; ovf = 1 iff sign(a) != sign(b) and sign(diff) != sign(a).

Function
REQ-015 Per bit, the block SHALL compute g = ~a & b (borrow generate), p = ~(a ^ b) (borrow propagate), and d = a ^ b ^ borrow_in.
- Within each 3-bit slice, borrows SHALL be computed in look-ahead form: b1 = g0 | p0&b0; b2 = g1 | p1&g0 | p1&p0&b0; bout = g2 | p2&g1 | p2&p1&g0 | p2&p1&p0&b0.
- Borrows SHALL NOT ripple bit-to-bit inside a slice.
REQ-016 The datapath SHALL be a pipeline of N = WIDTH/3 stages.
- Stage k SHALL resolve bits [3k+2:3k] using the registered borrow from stage k-1.
- Stage 0 SHALL use bin as its borrow-in.
- Unresolved upper operand bits and already-resolved lower diff bits SHALL travel with each stage.
REQ-017 Latency SHALL be exactly N cycles from the accept edge (in_valid & in_ready) to out_valid, provided no stall occurs (12-bit: 4 cycles).
REQ-018 Each stage SHALL hold a valid bit.
- Stage k SHALL advance when it is empty or when stage k+1 advances.
- The last stage SHALL advance when out_ready is high or when it is empty.
REQ-019 in_ready SHALL equal (stage 0 empty) OR (stage 0 advances) in the same cycle. It SHALL be combinational from out_ready through the advance chain, and SHALL have no dependence on in_valid.
REQ-020 Throughput SHALL be one result per cycle while out_ready = 1. Bubbles SHALL propagate as invalid stages, and results SHALL emerge in acceptance order.
REQ-021 While out_valid = 1 and out_ready = 0, diff, bout and ovf SHALL hold stable. No result SHALL be dropped or duplicated.
REQ-022 Inputs presented while in_ready = 0 SHALL be ignored.

Reset
REQ-023 When rst = 1 at a clock edge, all stage valid bits SHALL clear. out_valid SHALL be 0 and in_ready SHALL be 1 in the following cycle.
REQ-024 After reset, diff, bout and ovf SHALL read 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight results; none SHALL appear after reset.

Configuration
REQ-026 With macro BLS_FLAGS_EN defined, the block SHALL add two 1-bit output ports:
- out_zero = (diff == 0)
- out_neg = diff[WIDTH-1]
Both SHALL be registered with the final stage and reset to 0.
REQ-027 Without BLS_FLAGS_EN, those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 A shared package SHALL hold: SLICE_W = 3; a function for the stage count, WIDTH/3; and the per-stage payload struct type (valid, borrow, partial diff, remaining a/b bits).
REQ-029 A combinational sub-module borrow_lookahead_slice SHALL implement one 3-bit slice with ports a[2:0], b[2:0], bin, d[2:0], bout. It SHALL be instantiated N times.

Verification
REQ-030 The bench SHALL cover each scenario below (WIDTH = 12, out_ready = 1 unless stated):
- a=0x000, b=0x000, bin=0 -> diff=0x000, bout=0, ovf=0, out_valid exactly 4 cycles after accept.
- a=0x000, b=0x001, bin=0 -> diff=0xFFF, bout=1, ovf=0; a=0x7FF, b=0x7FF, bin=1 -> diff=0xFFF, bout=1, ovf=0.
- a=0x800, b=0x001, bin=0 -> diff=0x7FF, bout=0, ovf=1; a=0x7FF, b=0xFFF, bin=0 -> diff=0x800, bout=1, ovf=1.
- 8 back-to-back transactions with out_ready held 0 from cycle 2 for 10 cycles:
  - in_ready SHALL fall once 4 results are buffered.
  - Outputs SHALL hold stable during the stall.
  - After release, all 8 results SHALL emerge in order, one per cycle.
- rst pulsed 2 cycles after 3 accepts -> out_valid=0 and in_ready=1 next cycle; no stale result ever appears.
- Random 10,000 operands with random valid/ready gaps, against a reference model -> zero mismatches.
  - With BLS_FLAGS_EN: a=0x123, b=0x123 -> out_zero=1, out_neg=0.

Source files
------------

// File: rtl/borrow_lookahead_subtractor_pkg.sv
// Shared constants, stage-count helper and per-stage payload type for the
// borrow look-ahead subtractor pipeline.
package borrow_lookahead_subtractor_pkg;

  localparam int SLICE_W = 3;
  // Payload fields are sized for the widest supported operand; each stage
  // only carries meaningful bits in the low WIDTH positions.
  localparam int MAX_W   = 96;

  function automatic int stage_count(input int width);
    return width / SLICE_W;
  endfunction

  typedef struct packed {
    logic             valid;
    logic             borrow;
    logic [MAX_W-1:0] diff;
    logic [MAX_W-1:0] a_rem;
    logic [MAX_W-1:0] b_rem;
  } stage_t;

endpackage

// File: rtl/borrow_lookahead_slice.sv
// One 3-bit subtract slice; all internal borrows are formed directly from
// generate/propagate terms rather than rippling bit to bit.
module borrow_lookahead_slice
  import borrow_lookahead_subtractor_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic               w_b1;
  logic               w_b2;

  assign w_g  = ~a & b;
  assign w_p  = ~(a ^ b);

  assign w_b1 = w_g[0] | (w_p[0] & bin);
  assign w_b2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bin);
  assign bout = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & bin);

  assign d    = a ^ b ^ {w_b2, w_b1, bin};

endmodule

// File: rtl/borrow_lookahead_subtractor.sv
// Pipelined a - b - bin, one 3-bit slice per stage with valid/ready flow control.
// Define BLS_FLAGS_EN to add registered out_zero / out_neg result flags.
module borrow_lookahead_subtractor
  import borrow_lookahead_subtractor_pkg::*;
#(
  parameter int WIDTH = 12
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
`ifdef BLS_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg
`endif
);

  localparam int N  = stage_count(WIDTH);
  localparam int NS = (N > 1) ? N - 1 : 1;

  // Stages 0..N-2 live in r_stg; stage N-1 is the output register set.
  stage_t           r_stg [NS];
  logic             r_out_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic [N-1:0]              w_vld;
  logic [N-1:0]              w_adv;
  logic [N-1:0]              w_src_v;
  logic [N-1:0]              w_src_borrow;
  logic [N-1:0]              w_slice_bout;
  logic [N-1:0][MAX_W-1:0]   w_src_a;
  logic [N-1:0][MAX_W-1:0]   w_src_b;
  logic [N-1:0][MAX_W-1:0]   w_src_diff;
  logic [N-1:0][SLICE_W-1:0] w_d;
  logic [MAX_W-1:0]          w_full;
  logic                      w_unused;

  always_comb begin
    w_vld = '0;
    for (int k = 0; k < N - 1; k++) begin
      w_vld[k] = r_stg[k].valid;
    end
    w_vld[N-1] = r_out_valid;
  end

  always_comb begin
    w_src_v         = '0;
    w_src_borrow    = '0;
    w_src_a         = '0;
    w_src_b         = '0;
    w_src_diff      = '0;
    w_src_v[0]      = in_valid;
    w_src_borrow[0] = bin;
    w_src_a[0]      = MAX_W'(a);
    w_src_b[0]      = MAX_W'(b);
    for (int k = 1; k < N; k++) begin
      w_src_v[k]      = r_stg[k-1].valid;
      w_src_borrow[k] = r_stg[k-1].borrow;
      w_src_a[k]      = r_stg[k-1].a_rem;
      w_src_b[k]      = r_stg[k-1].b_rem;
      w_src_diff[k]   = r_stg[k-1].diff;
    end
  end

  // A stage moves when some stage at or below the output has a hole, or the
  // consumer takes the result; written flat so the chain has no self-loop.
  for (genvar k = 0; k < N; k++) begin : g_stage
    assign w_adv[k] = out_ready | ~(&w_vld[N-1:k]);

    borrow_lookahead_slice u_slice (
      .a   (w_src_a[k][SLICE_W-1:0]),
      .b   (w_src_b[k][SLICE_W-1:0]),
      .bin (w_src_borrow[k]),
      .d   (w_d[k]),
      .bout(w_slice_bout[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NS; k++) begin
        r_stg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N - 1; k++) begin
        if (w_adv[k]) begin
          r_stg[k].valid <= w_src_v[k];
          if (w_src_v[k]) begin
            r_stg[k].borrow <= w_slice_bout[k];
            r_stg[k].diff   <= w_src_diff[k] | (MAX_W'(w_d[k]) << (SLICE_W * k));
            r_stg[k].a_rem  <= w_src_a[k] >> SLICE_W;
            r_stg[k].b_rem  <= w_src_b[k] >> SLICE_W;
          end
        end
      end
    end
  end

  assign w_full = w_src_diff[N-1] | (MAX_W'(w_d[N-1]) << (SLICE_W * (N - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_adv[N-1]) begin
      r_out_valid <= w_src_v[N-1];
      if (w_src_v[N-1]) begin
        r_diff <= w_full[WIDTH-1:0];
        r_bout <= w_slice_bout[N-1];
        r_ovf  <= (w_src_a[N-1][SLICE_W-1] != w_src_b[N-1][SLICE_W-1]) &&
                  (w_d[N-1][SLICE_W-1] != w_src_a[N-1][SLICE_W-1]);
      end
    end
  end

`ifdef BLS_FLAGS_EN
  logic r_zero;
  logic r_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_adv[N-1] && w_src_v[N-1]) begin
      r_zero <= (w_full[WIDTH-1:0] == '0);
      r_neg  <= w_full[WIDTH-1];
    end
  end

  assign out_zero = r_zero;
  assign out_neg  = r_neg;
`endif

  // Operand bits left over after the top slice and padding above WIDTH.
  assign w_unused = ^{w_src_a[N-1][MAX_W-1:SLICE_W], w_src_b[N-1][MAX_W-1:SLICE_W],
                      w_full[MAX_W-1:WIDTH]};

  assign in_ready  = w_adv[0];
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_borrow_lookahead_subtractor.sv
// Scoreboard bench for borrow_lookahead_subtractor (WIDTH = 12); build with
// BLS_FLAGS_EN defined to also check out_zero / out_neg.
module tb_borrow_lookahead_subtractor;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
`ifdef BLS_FLAGS_EN
  logic         out_zero;
  logic         out_neg;
`endif

  borrow_lookahead_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .ovf      (ovf)
`ifdef BLS_FLAGS_EN
    ,
    .out_zero (out_zero),
    .out_neg  (out_neg)
`endif
  );

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  // Hand-computed directed vectors: a, b, bin -> diff, bout, ovf.
  vec_t dir_v [8] = '{
    '{12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0},
    '{12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0},
    '{12'h7FF, 12'h7FF, 1'b1, 12'hFFF, 1'b1, 1'b0},
    '{12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b1},
    '{12'h7FF, 12'hFFF, 1'b0, 12'h800, 1'b1, 1'b1},
    '{12'hFFF, 12'h000, 1'b1, 12'hFFE, 1'b0, 1'b0},
    '{12'h123, 12'h123, 1'b0, 12'h000, 1'b0, 1'b0},
    '{12'h555, 12'hAAA, 1'b0, 12'hAAB, 1'b1, 1'b1}
  };

  // Burst: a = 0x200 + i, b = 0x001 -> diff = 0x1FF + i.
  vec_t burst_v [8] = '{
    '{12'h200, 12'h001, 1'b0, 12'h1FF, 1'b0, 1'b0},
    '{12'h201, 12'h001, 1'b0, 12'h200, 1'b0, 1'b0},
    '{12'h202, 12'h001, 1'b0, 12'h201, 1'b0, 1'b0},
    '{12'h203, 12'h001, 1'b0, 12'h202, 1'b0, 1'b0},
    '{12'h204, 12'h001, 1'b0, 12'h203, 1'b0, 1'b0},
    '{12'h205, 12'h001, 1'b0, 12'h204, 1'b0, 1'b0},
    '{12'h206, 12'h001, 1'b0, 12'h205, 1'b0, 1'b0},
    '{12'h207, 12'h001, 1'b0, 12'h206, 1'b0, 1'b0}
  };

  exp_t sb_q [$];
  int   pop_hist [$];
  int   checks      = 0;
  int   failures    = 0;
  int   cyc         = 0;
  int   acc_count   = 0;
  int   acc_cyc     = 0;
  int   pop_count   = 0;
  int   last_pop_cyc = -1;
  logic rand_ready  = 1'b0;
  logic ready_force = 1'b1;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    logic [W:0] t;
    exp_t       r;
    t      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    r.diff = t[W-1:0];
    r.bout = t[W];
    r.ovf  = (ma[W-1] != mb[W-1]) && (r.diff[W-1] != ma[W-1]);
    return r;
  endfunction

  // Consumer handshake driver; runs after the main process's +1 updates.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks that a
  // stalled result holds still until taken.
  initial begin
    exp_t e;
    exp_t held;
    logic hold_pend;
    hold_pend = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend)
          check("hold_stable", 32'({out_valid, diff, bout, ovf}), 32'({1'b1, held}));
        hold_pend = out_valid && !out_ready;
        held      = {diff, bout, ovf};
        if (out_valid && out_ready) begin
          pop_count++;
          last_pop_cyc = cyc;
          pop_hist.push_back(cyc);
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got diff=0x%0h with nothing outstanding (cycle %0d)", diff, cyc);
          end else begin
            e = sb_q.pop_front();
            check("result", 32'({diff, bout, ovf}), 32'(e));
`ifdef BLS_FLAGS_EN
            check("out_zero", 32'(out_zero), 32'(e.diff == '0));
            check("out_neg", 32'(out_neg), 32'(e.diff[W-1]));
`endif
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin, input exp_t e);
    int n;
    n        = 0;
    a        = ta;
    b        = tb;
    bin      = tbin;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        acc_count++;
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      n++;
      if (n > 1000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic idle(input int nc);
    in_valid = 1'b0;
    repeat (nc) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pops(input int target, input string name);
    int n;
    n = 0;
    while (pop_count < target && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(pop_count), 32'(target));
  endtask

  initial begin
    int           start_cyc;
    int           h0;
    int           a0;
    int           p0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    bin      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_outputs", 32'({diff, bout, ovf}), 32'd0);
    @(posedge clk);
    #1;

    // Single transaction: latency from accept to out_valid.
    send(dir_v[0].a, dir_v[0].b, dir_v[0].bin, {dir_v[0].d, dir_v[0].bo, dir_v[0].ov});
    start_cyc = acc_cyc;
    idle(1);
    wait_pops(1, "first_result");
    check("latency", 32'(last_pop_cyc - start_cyc), 32'd4);

    // Remaining directed vectors, back to back.
    for (int i = 1; i < 8; i++)
      send(dir_v[i].a, dir_v[i].b, dir_v[i].bin, {dir_v[i].d, dir_v[i].bo, dir_v[i].ov});
    idle(1);
    wait_pops(8, "directed_results");

    // Burst of 8 with the consumer stalled for 10 cycles starting 2 cycles in.
    h0 = pop_hist.size();
    a0 = acc_count;
    p0 = pop_count;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(burst_v[i].a, burst_v[i].b, burst_v[i].bin,
               {burst_v[i].d, burst_v[i].bo, burst_v[i].ov});
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        ready_force = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_buffered", 32'(acc_count - a0), 32'd4);
        check("stall_no_output", 32'(pop_count - p0), 32'd0);
        @(posedge clk);
        #1;
        ready_force = 1'b1;
      end
    join
    wait_pops(p0 + 8, "burst_results");
    if (pop_hist.size() >= h0 + 8)
      check("burst_back_to_back", 32'(pop_hist[h0+7] - pop_hist[h0]), 32'd7);

    // Reset two cycles after three accepts: everything in flight is dropped.
    idle(2);
    p0 = pop_count;
    send(12'h321, 12'h0AB, 1'b0, model(12'h321, 12'h0AB, 1'b0));
    send(12'h456, 12'h789, 1'b1, model(12'h456, 12'h789, 1'b1));
    send(12'hABC, 12'h111, 1'b0, model(12'hABC, 12'h111, 1'b0));
    idle(1);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_outputs", 32'({diff, bout, ovf}), 32'd0);
    @(posedge clk);
    #1;
    idle(12);
    check("no_stale_after_rst", 32'(pop_count), 32'(p0));

    // Random operands with random input gaps and consumer back-pressure.
    p0 = pop_count;
    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0)
        idle(int'($urandom_range(1, 3)));
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      send(ra, rb, rbin, model(ra, rb, rbin));
    end
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    wait_pops(p0 + 10000, "random_results");
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
